// File: rtl/lsu_load_align.sv
// Load-alignment unit: issues one or two aligned word reads per load and returns
// the addressed bytes shifted down and sign- or zero-extended.
module lsu_load_align #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsign,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err
);

  localparam int unsigned B     = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(B);
  localparam int unsigned SH_W  = OFF_W + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                unsign_q, unsign_d;
  logic                split_q, split_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                req_ready_q, req_ready_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [4:0]          req_end_c;
  logic                req_split_c;
  logic                req_illegal_c;
  logic [ADDR_W-1:0]   req_align_c;
  logic [ADDR_W-1:0]   align_c;

  logic [DATA_W-1:0]   lo_src_c;
  logic [DATA_W-1:0]   hi_src_c;
  logic [SH_W-1:0]     shamt_c;
  logic [DATA_W-1:0]   shifted_c;
  logic [7:0]          keep_bits_c;
  logic                sign_c;
  logic                fill_c;
  logic [DATA_W-1:0]   result_c;

  // Request classification, evaluated on the incoming request in IDLE.
  always_comb begin
    req_end_c     = 5'(i_req_addr[OFF_W-1:0]) + (5'(1) << i_req_size);
    req_split_c   = req_end_c > 5'(B);
    req_illegal_c = (i_req_size > 2'(OFF_W)) ||
                    ((MISALIGN_SPLIT == 0) && req_split_c);
    req_align_c   = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    align_c       = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Extract and extend; the word arriving this cycle is used directly so the
  // result can be registered on the same edge that ends the wait.
  always_comb begin
    lo_src_c    = (state_q == S_WAIT0) ? i_mem_rdata : lo_q;
    hi_src_c    = (state_q == S_WAIT1) ? i_mem_rdata : '0;
    shamt_c     = {addr_q[OFF_W-1:0], 3'b000};
    shifted_c   = DATA_W'({hi_src_c, lo_src_c} >> shamt_c);
    keep_bits_c = 8'(8) << size_q;
    case (size_q)
      2'd0:    sign_c = shifted_c[7];
      2'd1:    sign_c = shifted_c[15];
      2'd2:    sign_c = shifted_c[31];
      default: sign_c = shifted_c[DATA_W-1];
    endcase
    fill_c   = !unsign_q && sign_c;
    result_c = shifted_c;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i >= int'(keep_bits_c)) begin
        result_c[i] = fill_c;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsign_d   = unsign_q;
    split_d    = split_q;
    lo_d       = lo_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          addr_d   = i_req_addr;
          size_d   = i_req_size;
          unsign_d = i_req_unsign;
          split_d  = req_split_c;
          if (req_illegal_c) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d    = S_REQ0;
            mem_addr_d = req_align_c;
          end
        end
      end
      S_REQ0: begin
        if (i_mem_ready) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (i_mem_rvalid) begin
          lo_d = i_mem_rdata;
          if (split_q) begin
            state_d    = S_REQ1;
            mem_addr_d = align_c + ADDR_W'(B);
          end else begin
            state_d    = S_RESP;
            rsp_data_d = result_c;
            rsp_err_d  = 1'b0;
          end
        end
      end
      S_REQ1: begin
        if (i_mem_ready) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (i_mem_rvalid) begin
          state_d    = S_RESP;
          rsp_data_d = result_c;
          rsp_err_d  = 1'b0;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    mem_valid_d = (state_d == S_REQ0) || (state_d == S_REQ1);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      unsign_q    <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      unsign_q    <= unsign_d;
      split_q     <= split_d;
      lo_q        <= lo_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_load_align.sv
// Directed bench for lsu_load_align: vector table on a split-enabled instance,
// plus stall, reset and no-split sequences.
module tb_lsu_load_align;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Split-enabled instance with a small memory model.
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsign = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // No-split instance, driven by hand.
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [31:0] s_req_addr = '0;
  logic [1:0]  s_req_size = '0;
  logic        s_req_unsign = 1'b0;
  logic        s_mem_valid;
  logic        s_mem_ready = 1'b1;
  logic [31:0] s_mem_addr;
  logic        s_mem_rvalid = 1'b0;
  logic [31:0] s_mem_rdata = '0;
  logic        s_rsp_valid;
  logic        s_rsp_ready = 1'b1;
  logic [31:0] s_rsp_data;
  logic        s_rsp_err;

  lsu_load_align #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_size(req_size), .i_req_unsign(req_unsign),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err)
  );

  lsu_load_align #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_nosplit (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(s_req_valid), .o_req_ready(s_req_ready), .i_req_addr(s_req_addr),
    .i_req_size(s_req_size), .i_req_unsign(s_req_unsign),
    .o_mem_valid(s_mem_valid), .i_mem_ready(s_mem_ready), .o_mem_addr(s_mem_addr),
    .i_mem_rvalid(s_mem_rvalid), .i_mem_rdata(s_mem_rdata),
    .o_rsp_valid(s_rsp_valid), .i_rsp_ready(s_rsp_ready), .o_rsp_data(s_rsp_data),
    .o_rsp_err(s_rsp_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h8433_2211;
      32'h0000_0104: return 32'hCCBB_AA99;
      32'hFFFF_FFFC: return 32'h5566_7788;
      32'h0000_0000: return 32'h0000_00F0;
      default:       return 32'h0BAD_F00D;
    endcase
  endfunction

  // Memory: data one cycle after each accepted read; mem_hold swallows reads,
  // inject produces an unsolicited beat.
  logic        mem_hold = 1'b0;
  logic        inject = 1'b0;
  logic [31:0] rd_log [0:63];
  int          rd_cnt = 0;

  always @(posedge clk) begin
    mem_rvalid <= inject;
    if (inject) mem_rdata <= 32'hFEED_FACE;
    if (mem_valid && mem_ready) begin
      rd_log[rd_cnt % 64] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
      if (!mem_hold) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_word(mem_addr);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_reads;
    logic [31:0] exp_rd0;
    int          mstall;
    int          rstall;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [0:NV-1];

  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input int mstall, input int rstall,
                          output logic [31:0] d, output logic e, output int lat,
                          output int nrd, output logic [31:0] rd0, output logic [31:0] rd1);
    int base;
    int ms;
    bit found;
    logic [31:0] addr_seen;
    @(negedge clk);
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    mem_ready  = (mstall == 0);
    rsp_ready  = (rstall == 0);
    ms         = mstall;
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_unsign = u;
    base       = rd_cnt;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'hDEAD_BEEF;
    req_size   = 2'd3;
    req_unsign = ~u;
    found      = 1'b0;
    lat        = 0;
    addr_seen  = '0;
    for (int c = 1; c <= 60 && !found; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        lat   = c;
      end else if (mem_valid) begin
        if (ms > 0) begin
          if (ms == mstall) addr_seen = mem_addr;
          else chk("mem_addr_stable_in_stall", mem_addr, addr_seen);
          ms--;
          mem_ready = 1'b0;
        end else begin
          mem_ready = 1'b1;
        end
      end
    end
    if (!found) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      rsp_ready = 1'b1;
      mem_ready = 1'b1;
      d = '0; e = 1'b0; nrd = 0; rd0 = '0; rd1 = '0;
      return;
    end
    d = rsp_data;
    e = rsp_err;
    for (int k = 0; k < rstall; k++) begin
      @(negedge clk);
      chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
      chk("rsp_data_held", rsp_data, d);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    nrd = rd_cnt - base;
    rd0 = rd_log[base % 64];
    rd1 = rd_log[(base + 1) % 64];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, rd0, rd1;
    logic        e;
    int          lat, nrd;

    //           addr          sz  u  data          err lat rd rd0           ms rs
    vecs[0]  = '{32'h0000_0103, 0, 0, 32'hFFFF_FF84, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[1]  = '{32'h0000_0103, 0, 1, 32'h0000_0084, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[2]  = '{32'h0000_0102, 1, 0, 32'hFFFF_8433, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[3]  = '{32'h0000_0102, 1, 1, 32'h0000_8433, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[4]  = '{32'h0000_0102, 2, 0, 32'hAA99_8433, 0, 5, 2, 32'h0000_0100, 0, 0};
    vecs[5]  = '{32'h0000_0103, 1, 0, 32'hFFFF_9984, 0, 5, 2, 32'h0000_0100, 0, 0};
    vecs[6]  = '{32'h0000_0100, 3, 0, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 0, 0};
    vecs[7]  = '{32'h0000_0100, 2, 0, 32'h8433_2211, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[8]  = '{32'h0000_0100, 0, 0, 32'h0000_0011, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[9]  = '{32'h0000_0101, 1, 1, 32'h0000_3322, 0, 3, 1, 32'h0000_0100, 0, 0};
    vecs[10] = '{32'h0000_0103, 2, 0, 32'hBBAA_9984, 0, 5, 2, 32'h0000_0100, 0, 0};
    vecs[11] = '{32'h0000_0104, 0, 1, 32'h0000_0099, 0, 3, 1, 32'h0000_0104, 0, 0};
    vecs[12] = '{32'h0000_0104, 0, 0, 32'hFFFF_FF99, 0, 3, 1, 32'h0000_0104, 0, 0};
    vecs[13] = '{32'hFFFF_FFFE, 2, 0, 32'h00F0_5566, 0, 5, 2, 32'hFFFF_FFFC, 0, 0};
    vecs[14] = '{32'hFFFF_FFFF, 1, 0, 32'hFFFF_F055, 0, 5, 2, 32'hFFFF_FFFC, 0, 0};
    vecs[15] = '{32'h0000_0100, 2, 0, 32'h8433_2211, 0, 5, 1, 32'h0000_0100, 2, 0};
    vecs[16] = '{32'h0000_0102, 1, 0, 32'hFFFF_8433, 0, 3, 1, 32'h0000_0100, 0, 3};
    vecs[17] = '{32'h0000_0106, 1, 1, 32'h0000_CCBB, 0, 3, 1, 32'h0000_0104, 0, 0};
    vecs[18] = '{32'h0000_0104, 2, 0, 32'hCCBB_AA99, 0, 3, 1, 32'h0000_0104, 0, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_nosplit_req_ready", 32'(s_req_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_load(vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].mstall, vecs[i].rstall,
               d, e, lat, nrd, rd0, rd1);
      chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_reads", i), 32'(nrd), 32'(vecs[i].exp_reads));
      if (vecs[i].exp_reads >= 1) chk($sformatf("v%0d_rd0_addr", i), rd0, vecs[i].exp_rd0);
      if (vecs[i].exp_reads == 2) chk($sformatf("v%0d_rd1_addr", i), rd1, vecs[i].exp_rd0 + 32'd4);
    end

    // Reset while waiting on the second read of a split load; then a late beat.
    @(negedge clk);
    mem_ready  = 1'b1;
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0102;
    req_size   = 2'd2;
    req_unsign = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_seq_req1_valid", 32'(mem_valid), 32'd1);
    chk("rst_seq_req1_addr", mem_addr, 32'h0000_0104);
    mem_hold = 1'b1;
    @(negedge clk);
    chk("rst_seq_wait1_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_seq_wait1_no_mem_valid", 32'(mem_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_seq_req_ready", 32'(req_ready), 32'd1);
    chk("rst_seq_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_seq_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_seq_mem_addr", mem_addr, 32'd0);
    mem_hold = 1'b0;
    inject   = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray_rvalid_no_rsp_%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("stray_rvalid_idle_%0d", k), 32'(req_ready), 32'd1);
      chk($sformatf("stray_rvalid_no_mem_%0d", k), 32'(mem_valid), 32'd0);
    end
    run_load(32'h0000_0103, 2'd0, 1'b0, 0, 0, d, e, lat, nrd, rd0, rd1);
    chk("post_reset_data", d, 32'hFFFF_FF84);
    chk("post_reset_latency", 32'(lat), 32'd3);

    // No-split instance: a straddling word load is rejected without any read.
    @(negedge clk);
    s_req_valid  = 1'b1;
    s_req_addr   = 32'h0000_0102;
    s_req_size   = 2'd2;
    s_req_unsign = 1'b0;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    @(negedge clk);
    chk("nosplit_err_valid", 32'(s_rsp_valid), 32'd1);
    chk("nosplit_err_flag", 32'(s_rsp_err), 32'd1);
    chk("nosplit_err_data", s_rsp_data, 32'd0);
    chk("nosplit_err_no_mem", 32'(s_mem_valid), 32'd0);
    @(negedge clk);
    chk("nosplit_err_back_idle", 32'(s_req_ready), 32'd1);
    chk("nosplit_err_rsp_done", 32'(s_rsp_valid), 32'd0);

    // No-split instance: an in-word half still works.
    s_req_valid = 1'b1;
    s_req_size  = 2'd1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    @(negedge clk);
    chk("nosplit_lh_mem_valid", 32'(s_mem_valid), 32'd1);
    chk("nosplit_lh_mem_addr", s_mem_addr, 32'h0000_0100);
    @(negedge clk);
    s_mem_rvalid = 1'b1;
    s_mem_rdata  = 32'h8433_2211;
    @(posedge clk);
    #1;
    s_mem_rvalid = 1'b0;
    @(negedge clk);
    chk("nosplit_lh_valid", 32'(s_rsp_valid), 32'd1);
    chk("nosplit_lh_err", 32'(s_rsp_err), 32'd0);
    chk("nosplit_lh_data", s_rsp_data, 32'hFFFF_8433);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_load_align.md
# lsu_load_align

Parametrised load-alignment unit for the LSU. It accepts one load request at a time: address, access size and signed/unsigned flag. It issues one or two aligned word reads to the data memory over a valid/ready bus. It then extracts, shifts and sign- or zero-extends the addressed bytes and returns the result on a valid/ready response port. It sits between the LSU request logic and the data-memory port, and supports misaligned accesses that straddle a word boundary.

## Interface
- DATA_W, 32: memory word and result width in bits; power of two, 32 or 64.
- ADDR_W, 32: byte-address width.
- MISALIGN_SPLIT, 1: 1 = accesses crossing a word boundary are split into two reads; 0 = such accesses return an error.

- i_clk  in  1  clock, all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  load request valid.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_addr  in  ADDR_W  byte address.
- i_req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword.
- i_req_unsign  in  1  1 = zero-extend, 0 = sign-extend.
- o_mem_valid  out  1  memory read request valid.
- i_mem_ready  in  1  memory accepts the read.
- o_mem_addr  out  ADDR_W  word-aligned read address (low log2(DATA_W/8) bits = 0).
- i_mem_rvalid  in  1  read data valid (one beat per accepted read, in order).
- i_mem_rdata  in  DATA_W  read data, little-endian.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  consumer takes result.
- o_rsp_data  out  DATA_W  extended load result.
- o_rsp_err  out  1  request illegal; o_rsp_data = 0.

## Operation
- Let B = DATA_W/8, off = addr mod B, n = 1<<size.
- Illegal request: size > log2(B), or MISALIGN_SPLIT=0 and off+n > B.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: o_req_ready=1. On accept, latch the address, size, unsign flag and a split flag (off+n > B).
  - Illegal request → RESP with err=1.
  - Otherwise → REQ0.
- REQ0: o_mem_valid=1, o_mem_addr = addr with the low bits cleared. → WAIT0 on i_mem_ready.
- WAIT0: on i_mem_rvalid, latch lo = i_mem_rdata. → REQ1 if split, else RESP.
- REQ1: o_mem_valid=1, o_mem_addr = aligned addr + B, wrapping modulo 2^ADDR_W. → WAIT1 on i_mem_ready.
- WAIT1: on i_mem_rvalid, latch hi = i_mem_rdata. → RESP.
- Result computation: form {hi, lo} (hi = 0 when not split) and shift it right by off*8. Keep the low n*8 bits. Bits above are filled with the top kept bit when unsign=0, and with 0 when unsign=1. For n = B, no extension applies.
- RESP: o_rsp_valid=1; o_rsp_data and o_rsp_err are registered and stable. → IDLE on i_rsp_ready.
- i_mem_rvalid outside WAIT0/WAIT1 is ignored.
- i_req_* is ignored outside IDLE.

## Timing
- Reset values: state IDLE, o_mem_valid=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_mem_addr=0.
  - o_req_ready=1 in the first cycle after reset deasserts.
- Reset has priority in any state. It drops any outstanding read; a later stray rvalid is ignored because the block is in IDLE.
- All outputs decode from state and registers only; there is no combinational path from inputs to outputs.
- Latency from the accept edge to o_rsp_valid, with zero-wait memory (ready high, rvalid the cycle after the read is accepted):
  - aligned: 3 cycles;
  - split: 5 cycles;
  - illegal: 1 cycle.
- Each cycle of i_mem_ready=0 or i_mem_rvalid=0 adds one cycle of latency.
- rvalid in the same cycle as the read handshake is not allowed; the memory must return data at least one cycle after accepting the read.
- The next request can be accepted in the cycle after the RESP handshake, giving maximum throughput of one aligned load per 4 cycles.

## Test plan
Memory for all scenarios: word 0x100 = 0x84332211, word 0x104 = 0xCCBBAA99 (DATA_W=32).
- lb 0x103 signed → 0xFFFFFF84; lbu 0x103 → 0x00000084. One mem read at 0x100, err=0, 3-cycle latency.
- lh 0x102 → 0xFFFF8433; lhu 0x102 → 0x00008433.
- lw 0x102, MISALIGN_SPLIT=1 → reads at 0x100 then 0x104, result 0xAA998433, 5-cycle latency.
- lh 0x103 → 0xFFFF9984 (split).
- Illegal cases, each → o_rsp_err=1, data 0, o_mem_valid never asserted:
  - size=3 on DATA_W=32;
  - lw 0x102 with MISALIGN_SPLIT=0.
- Stall and reset:
  - hold i_mem_ready=0 for 2 cycles → o_mem_addr stable;
  - hold i_rsp_ready=0 for 3 cycles → data stable;
  - assert i_reset while in WAIT1, then deliver a late rvalid → no response, block in IDLE with o_req_ready=1.
